// File: rtl/alu_arbiter_pkg.sv
// Shared types for alu_arbiter: ALU op codes, FSM states and the op-legality helper.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_PASS_A = 4'd0,
    OP_ADD    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRL    = 4'd5,
    OP_SUB    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_NOR    = 4'd9,
    OP_SGT    = 4'd10
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and alu_arbiter.
interface alu_arbiter_if #(parameter int TAGW = 4);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_a;
  logic [1:0][31:0]      req_b;
  logic [1:0][3:0]       req_op;
  logic [1:0][TAGW-1:0]  req_tag;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [31:0]           rsp_data;
  logic [TAGW-1:0]       rsp_tag;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; shifts move data_b by data_a[4:0], unknown ops yield 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_PASS_A: result = data_a;
      OP_ADD:    result = data_a + data_b;
      OP_AND:    result = data_a & data_b;
      OP_OR:     result = data_a | data_b;
      OP_SLL:    result = data_b << data_a[4:0];
      OP_SRL:    result = data_b >> data_a[4:0];
      OP_SUB:    result = data_a - data_b;
      OP_SRA:    result = 32'($signed(data_b) >>> data_a[4:0]);
      OP_SLT:    result = {31'b0, $signed(data_a) < $signed(data_b)};
      OP_NOR:    result = ~(data_a | data_b);
      OP_SGT:    result = {31'b0, $signed(data_a) > $signed(data_b)};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              owner_q;
  logic [31:0]       data_q;
  logic [TAGW-1:0]   tag_q;
  logic              err_q;
  logic              prio_q;
  logic              win;
  logic              can_accept;
  logic              accept;
  logic [31:0]       alu_y;

`ifdef ALU_ARB_RR_EN
  // Pointer names the requester favoured on the next contention.
  always_ff @(posedge clk) begin
    if (rst)         prio_q <= 1'b0;
    else if (accept) prio_q <= ~win;
  end
`else
  assign prio_q = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win = bus.req_valid[1];
    if (bus.req_valid == 2'b11) win = prio_q;
  end

  assign can_accept = !rst && ((state_q == ST_IDLE) || bus.rsp_ready[owner_q]);
  assign accept     = can_accept && (|bus.req_valid);

  alu u_alu (
    .data_a (bus.req_a[win]),
    .data_b (bus.req_b[win]),
    .op     (bus.req_op[win]),
    .result (alu_y)
  );

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready[owner_q]) state_d = accept ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    if (accept) bus.req_ready = {win, ~win};
    if (!rst && state_q == ST_RESP) bus.rsp_valid = {owner_q, ~owner_q};
  end

  // NOTE: the result registers are reset because the cleared rsp_data/rsp_tag values are externally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      owner_q <= win;
      data_q  <= op_illegal(bus.req_op[win]) ? 32'd0 : alu_y;
      tag_q   <= bus.req_tag[win];
      err_q   <= op_illegal(bus.req_op[win]);
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_tag  = tag_q;
  assign bus.rsp_err  = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TAGW, default 4, SHALL set the width of the requester tag carried through with each operation.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester operation request.
REQ-005 req_ready  output  2  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-006 req_a, req_b  input  2x32 each  per-requester operands (ALU data_a, data_b).
REQ-007 req_op  input  2x4  per-requester ALU pattern code.
REQ-008 req_tag  input  2xTAGW  per-requester tag.
REQ-009 rsp_valid  output  2  result valid, one-hot to the owning requester.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_data  output  32  registered ALU result.
REQ-012 rsp_tag  output  TAGW  tag of the completed operation.
REQ-013 rsp_err  output  1  high with rsp_valid when the op code was greater than 10.

Function
REQ-014 The block SHALL share one combinational ALU between two requesters, with at most one operation in flight.
REQ-015 FSM states SHALL be IDLE (no result held) and RESP (result held, rsp_valid high to the owner).
REQ-016 In IDLE, req_ready SHALL be asserted only to the arbitration winner among requesters with req_valid high; there SHALL be no ready without a corresponding valid.
REQ-017 On accept, the block SHALL register the ALU output for the winner's operands, the tag, the owner index and the error flag, then move to RESP; result latency SHALL be 1 cycle (rsp_valid high in the cycle after the accept).
REQ-018 In RESP, rsp_data, rsp_tag, rsp_err and the owner SHALL hold stable until rsp_ready[owner] is high; rsp_ready of the non-owner SHALL be ignored.
REQ-019 In RESP, when rsp_ready[owner] is high, the block SHALL accept a new winner in the same cycle (req_ready may depend combinationally on rsp_ready) and stay in RESP, giving one operation per cycle; if no request is pending, it SHALL go to IDLE.
REQ-020 Op codes 11..15 SHALL produce rsp_data equal to 0 and rsp_err equal to 1; the rsp_err flag SHALL not alter the handshake.
REQ-021 A requester SHALL keep its operands stable while req_valid is high and unaccepted; the block SHALL sample them only on accept.

Reset
REQ-022 While rst is high, the state SHALL be IDLE; req_ready, rsp_valid and rsp_err SHALL be 0; rsp_data and rsp_tag SHALL be 0; the priority pointer SHALL favour requester 0.
REQ-023 A reset asserted while in RESP SHALL discard the held result without any handshake.

Configuration
REQ-024 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: after a grant to requester i, requester 1-i has priority on the next contention.
REQ-025 Without ALU_ARB_RR_EN, requester 0 SHALL always win on contention (fixed priority); the pointer register SHALL not exist.

Structure
REQ-026 A shared package SHALL hold the 4-bit ALU op enum (0 PASS_A, 1 ADD, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SUB, 7 SRA, 8 SLT, 9 NOR, 10 SGT) and the constant ALU_OP_MAX = 10.
REQ-027 The existing alu module SHALL be instantiated once as the only sub-module; arbitration and the FSM SHALL stay in alu_arbiter.

Verification
REQ-028 Single op: requester 0 sends ADD with a = 5, b = 7, tag = 3, rsp_ready held high -> the next cycle gives rsp_valid = 01, rsp_data = 12, rsp_tag = 3, rsp_err = 0.
REQ-029 Contention under RR: both requesters request continuously with rsp_ready high -> grants alternate 0,1,0,1 with one result per cycle; under fixed priority, requester 1 is never granted while requester 0 is valid.
REQ-030 Backpressure: the owner holds rsp_ready = 0 for 3 cycles with SUB a = 1, b = 2 -> rsp_data = 0xFFFFFFFF is held stable, and req_ready stays 0 for both requesters throughout.
REQ-031 Illegal op: op = 13, a = 0xFFFF, b = 1 -> rsp_data = 0, rsp_err = 1, and the handshake completes normally.
REQ-032 Reset mid-RESP: rst is pulsed while rsp_valid = 10 -> the next cycle has rsp_valid = 00, state IDLE, and the first subsequent contention is won by requester 0.
REQ-033 Shifts and compares: SRA a = 4, b = 0x80000000 -> 0xF8000000; SLT a = -1, b = 0 -> 1; SGT a = -1, b = 0 -> 0.
